ssd_scan_ctrl: RTL and testbench

Four-digit seven-segment scan controller sitting directly downstream of the binary-to-display data conditioner. It takes the four 4-bit digit codes D1..D4 and the display-mode select, snapshots them once per refresh frame, decodes each to a glyph, and time-multiplexes the common-anode display with anti-ghosting blanking. It also produces the once-per-frame strobe that the conditioner uses to start its next BCD conversion, so conversion and display stay frame-aligned.

---
 rtl/ssd_pkg.sv | 52 +++++
 rtl/seg7_decode.sv | 23 ++
 rtl/ssd_scan_ctrl.sv | 87 ++++++++
 tb/tb_ssd_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared glyph constants and special code points for the seven-segment scan path.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package ssd_pkg;

  localparam logic [3:0] CODE_BLANK  = 4'hA;
  localparam logic [3:0] CODE_DEGREE = 4'hB;
  localparam logic [3:0] CODE_MINUS  = 4'hF;

  localparam logic [6:0] GLYPH_0      = 7'b1000000;
  localparam logic [6:0] GLYPH_1      = 7'b1111001;
  localparam logic [6:0] GLYPH_2      = 7'b0100100;
  localparam logic [6:0] GLYPH_3      = 7'b0110000;
  localparam logic [6:0] GLYPH_4      = 7'b0011001;
  localparam logic [6:0] GLYPH_5      = 7'b0010010;
  localparam logic [6:0] GLYPH_6      = 7'b0000010;
  localparam logic [6:0] GLYPH_7      = 7'b1111000;
  localparam logic [6:0] GLYPH_8      = 7'b0000000;
  localparam logic [6:0] GLYPH_9      = 7'b0010000;
  localparam logic [6:0] GLYPH_A      = 7'b0001000;
  localparam logic [6:0] GLYPH_B      = 7'b0000011;
  localparam logic [6:0] GLYPH_C      = 7'b1000110;
  localparam logic [6:0] GLYPH_D      = 7'b0100001;
  localparam logic [6:0] GLYPH_E      = 7'b0000110;
  localparam logic [6:0] GLYPH_F      = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK  = 7'b1111111;
  localparam logic [6:0] GLYPH_MINUS  = 7'b0111111;
  localparam logic [6:0] GLYPH_DEGREE = 7'b0011100;

  function automatic logic [6:0] hex_glyph(input logic [3:0] code);
    logic [6:0] g;
    unique case (code)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to glyph decoder; mode 1 selects the BCD/symbol set,
// mode 0 the raw hex set.
module seg7_decode
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  input  logic       mode,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_glyph(code);
    // Above 9 the symbol set reuses codes: only degree and minus light anything.
    if (mode && (code > 4'h9)) begin
      unique case (code)
        CODE_DEGREE: seg = GLYPH_DEGREE;
        CODE_MINUS:  seg = GLYPH_MINUS;
        default:     seg = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode scan controller: per-frame input snapshot, glyph decode,
// anti-ghosting blanking at the start of each slot and a frame-boundary strobe.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       display_sel,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] D4,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_strobe
);

  localparam int unsigned TW = $clog2(DIGIT_CYCLES);
  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_TICK = TW'(BLANK_CYCLES);

  if (DIGIT_CYCLES < 2) begin : g_bad_digit
    $error("DIGIT_CYCLES must be at least 2");
  end
  if (BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank
    $error("BLANK_CYCLES must be less than DIGIT_CYCLES");
  end

  logic [TW-1:0]   tick_q;
  logic [1:0]      dig_q;
  logic [3:0][3:0] shadow_q;
  logic            mode_q;
  logic            tick_wrap;
  logic            frame_end;
  logic [3:0]      an_d;
  logic [6:0]      glyph;

  assign tick_wrap = (tick_q == TICK_LAST);
  assign frame_end = tick_wrap && (dig_q == 2'd3);

  seg7_decode u_decode (
    .code (shadow_q[dig_q]),
    .mode (mode_q),
    .seg  (glyph)
  );

  always_comb begin
    an_d = 4'b1111;
    // Slot 0 (D1) drives an[3], so the anode index is the bitwise inverse of dig.
    if (en && (tick_q >= BLANK_TICK)) begin
      an_d[~dig_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q       <= '0;
      dig_q        <= '0;
      shadow_q     <= {4{CODE_BLANK}};
      mode_q       <= 1'b1;
      an           <= 4'b1111;
      seg          <= GLYPH_BLANK;
      dp           <= 1'b1;
      frame_strobe <= 1'b0;
    end else begin
      tick_q <= tick_wrap ? '0 : tick_q + 1'b1;
      if (tick_wrap) begin
        dig_q <= dig_q + 2'd1;
      end
      // Snapshot only at the frame boundary so a frame never mixes old and new digits.
      if (frame_end) begin
        shadow_q <= {D4, D3, D2, D1};
        mode_q   <= display_sel;
      end
      an           <= an_d;
      seg          <= glyph;
      dp           <= 1'b1;
      frame_strobe <= frame_end;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomised bench for ssd_scan_ctrl against a frame-arithmetic reference model,
// plus an exhaustive sweep of seg7_decode.
module tb_ssd_scan_ctrl;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * DC;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       display_sel;
  logic [3:0] d1, d2, d3, d4;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_strobe;

  logic [3:0] dec_code;
  logic       dec_mode;
  logic [6:0] dec_seg;

  int checks = 0;
  int failures = 0;

  // Model state: edges since reset release, captured digits and mode.
  int         mk;
  int         cyc;
  int         last_fs;
  logic [3:0] m_sh [4];
  logic       m_mode;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .display_sel  (display_sel),
    .D1           (d1),
    .D2           (d2),
    .D3           (d3),
    .D4           (d4),
    .an           (an),
    .seg          (seg),
    .dp           (dp),
    .frame_strobe (frame_strobe)
  );

  seg7_decode u_dec (
    .code (dec_code),
    .mode (dec_mode),
    .seg  (dec_seg)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] c, input logic m);
    if (m && c == 4'hB) return 7'b0011100;
    if (m && c == 4'hF) return 7'b0111111;
    if (m && c >= 4'hA) return 7'b1111111;
    return hex_tbl[c];
  endfunction

  task automatic model_reset();
    mk = 0;
    cyc = 0;
    last_fs = -1;
    for (int i = 0; i < 4; i++) m_sh[i] = 4'hA;
    m_mode = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_an"}, an, 4'hF);
    check_eq({tag, "_seg"}, seg, 7'h7F);
    check_eq({tag, "_dp"}, dp, 1'b1);
    check_eq({tag, "_fs"}, frame_strobe, 1'b0);
  endtask

  // One clock edge; expectations come from the slot/tick position within the frame.
  task automatic cycle();
    logic [3:0] t_an;
    logic [6:0] t_seg;
    logic       t_fs;
    int         tick;
    int         dig;
    @(posedge clk);
    #1;
    tick  = mk % DC;
    dig   = (mk / DC) % 4;
    t_an  = 4'hF;
    if (en && tick >= BC) t_an[3 - dig] = 1'b0;
    t_seg = ref_glyph(m_sh[dig], m_mode);
    t_fs  = (tick == DC - 1) && (dig == 3);
    if (t_fs) begin
      m_sh[0] = d1;
      m_sh[1] = d2;
      m_sh[2] = d3;
      m_sh[3] = d4;
      m_mode  = display_sel;
    end
    mk++;
    cyc++;
    check_eq("an", an, t_an);
    check_eq("seg", seg, t_seg);
    check_eq("dp", dp, 1'b1);
    check_eq("frame_strobe", frame_strobe, t_fs);
    check_eq("an_onehot", ($countones(~an) <= 1), 1'b1);
    if (frame_strobe) begin
      if (last_fs < 0) check_eq("first_strobe", cyc, FRAME);
      else check_eq("strobe_period", cyc - last_fs, FRAME);
      last_fs = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input logic m);
    d1 = a;
    d2 = b;
    d3 = c;
    d4 = d;
    display_sel = m;
  endtask

  initial begin
    // Decoder on its own, every code in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 16; c++) begin
        dec_code = 4'(c);
        dec_mode = 1'(m);
        #1;
        check_eq($sformatf("dec_m%0d_c%0h", m, c), dec_seg, ref_glyph(4'(c), 1'(m)));
      end
    end

    rst = 1'b0;
    en = 1'b0;
    set_digits(4'h3, 4'h5, 4'h7, 4'h9, 1'b0);
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // First frame with the display disabled: fully dark until the first snapshot.
    set_digits(4'hF, 4'h1, 4'h2, 4'h3, 1'b1);
    run(FRAME);
    en = 1'b1;
    run(2 * FRAME);

    set_digits(4'h0, 4'hA, 4'hB, 4'hF, 1'b0);
    run(2 * FRAME);
    display_sel = 1'b1;
    run(2 * FRAME);

    // Change D1 mid-frame at slot 2; only the next frame may show it.
    set_digits(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    run(FRAME);
    while (mk % FRAME != 2 * DC) cycle();
    d1 = 4'h7;
    run(2 * FRAME);

    en = 1'b0;
    run(20);
    en = 1'b1;
    run(FRAME);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) begin
        set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      end
      if ($urandom_range(29) == 0) en = ~en;
      cycle();
    end

    // Asynchronous reset at slot 2, tick 5.
    en = 1'b1;
    set_digits(4'h8, 4'h8, 4'h8, 4'h8, 1'b0);
    run(FRAME);
    while (mk % FRAME != 2 * DC + 5) cycle();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    #20;
    check_reset_outputs("reset_held");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run(3 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
